systolic_array_nxn: RTL and testbench

Parametrised weight-stationary systolic MAC array: ROWS x COLS processing elements with built-in input skew, output de-skew and a weight-load controller. It generalises the fixed 2x2 array to arbitrary size. It adds ready/valid handshakes, a drain-before-reload state machine and signed wide accumulation. It sits between the activation buffer (input vectors) and the accumulator/result buffer (output vectors).

---
 rtl/systolic_array_nxn.sv | 184 ++++++++++++++++++
 tb/tb_systolic_array_nxn.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_nxn.sv
// Weight-stationary ROWS x COLS systolic MAC array with input skew, output de-skew
// and a drain-before-reload weight controller.
module systolic_array_nxn #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ACC_WIDTH  = 40,
   parameter int unsigned ROWS       = 4,
   parameter int unsigned COLS       = 4
) (
   input  logic                       sa_clk,
   input  logic                       sa_rst,
   input  logic                       sa_load,
   input  logic                       sa_w_valid,
   output logic                       sa_w_ready,
   input  logic [COLS*DATA_WIDTH-1:0] sa_w_in,
   input  logic                       sa_in_valid,
   output logic                       sa_in_ready,
   input  logic [ROWS*DATA_WIDTH-1:0] sa_a_in,
   output logic                       sa_out_valid,
   output logic [COLS*ACC_WIDTH-1:0]  sa_out,
   output logic                       sa_weights_ok
);

   localparam int unsigned Lat  = ROWS + COLS;
   localparam int unsigned CntW = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [1:0] StEmpty   = 2'd0;
   localparam logic [1:0] StDrain   = 2'd1;
   localparam logic [1:0] StLoading = 2'd2;
   localparam logic [1:0] StReady   = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] beat_q, beat_d;
   logic [Lat-1:0]  tok_q;
   logic            w_fire, in_fire, in_flight, last_beat;

   logic [DATA_WIDTH-1:0]      w_q     [ROWS][COLS];
   logic [DATA_WIDTH-1:0]      act_q   [ROWS][COLS];
   logic [ACC_WIDTH-1:0]       psum_q  [ROWS][COLS];
   logic [DATA_WIDTH-1:0]      row_act [ROWS];
   logic [ACC_WIDTH-1:0]       col_out [COLS];
   logic [ROWS*DATA_WIDTH-1:0] a_gated;

   assign sa_w_ready    = (state_q == StLoading);
   assign sa_in_ready   = (state_q == StReady);
   assign sa_weights_ok = (state_q == StReady);
   assign sa_out_valid  = tok_q[Lat-1];

   assign w_fire    = sa_w_valid & sa_w_ready;
   assign in_fire   = sa_in_valid & sa_in_ready;
   assign in_flight = |tok_q;
   assign last_beat = (beat_q == CntW'(ROWS - 1));
   assign a_gated   = in_fire ? sa_a_in : '0;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         StEmpty: if (sa_load) state_d = StLoading;
         StDrain: if (!in_flight) state_d = StLoading;
         StLoading: begin
            if (w_fire) begin
               if (last_beat) begin
                  beat_d  = '0;
                  state_d = StReady;
               end else begin
                  beat_d = beat_q + CntW'(1);
               end
            end
         end
         StReady: if (sa_load) state_d = StDrain;
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge sa_clk) begin
      if (sa_rst) begin
         state_q <= StEmpty;
         beat_q  <= '0;
         tok_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         tok_q   <= {tok_q[Lat-2:0], in_fire};
      end
   end

   // Each accepted row enters at the top and pushes older rows down one step.
   always_ff @(posedge sa_clk) begin
      if (sa_rst) begin
         for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
               w_q[r][c] <= '0;
            end
         end
      end else if (w_fire) begin
         for (int c = 0; c < int'(COLS); c++) begin
            w_q[0][c] <= sa_w_in[c*DATA_WIDTH +: DATA_WIDTH];
            for (int r = 1; r < int'(ROWS); r++) begin
               w_q[r][c] <= w_q[r-1][c];
            end
         end
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_skew
      if (r == 0) begin : g_direct
         assign row_act[r] = a_gated[0 +: DATA_WIDTH];
      end else begin : g_dly
         logic [DATA_WIDTH-1:0] dly_q [r];
         always_ff @(posedge sa_clk) begin
            if (sa_rst) begin
               for (int k = 0; k < r; k++) dly_q[k] <= '0;
            end else begin
               dly_q[0] <= a_gated[r*DATA_WIDTH +: DATA_WIDTH];
               for (int k = 1; k < r; k++) dly_q[k] <= dly_q[k-1];
            end
         end
         assign row_act[r] = dly_q[r-1];
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_pe
         logic [DATA_WIDTH-1:0] act_in;
         logic [ACC_WIDTH-1:0]  psum_in, a_ext, w_ext, prod;

         if (c == 0) begin : g_a_edge
            assign act_in = row_act[r];
         end else begin : g_a_chain
            assign act_in = act_q[r][c-1];
         end

         if (r == 0) begin : g_p_edge
            assign psum_in = '0;
         end else begin : g_p_chain
            assign psum_in = psum_q[r-1][c];
         end

         // Low ACC_WIDTH bits of the extended product equal the signed product.
         assign a_ext = {{(ACC_WIDTH-DATA_WIDTH){act_in[DATA_WIDTH-1]}}, act_in};
         assign w_ext = {{(ACC_WIDTH-DATA_WIDTH){w_q[r][c][DATA_WIDTH-1]}}, w_q[r][c]};
         assign prod  = a_ext * w_ext;

         always_ff @(posedge sa_clk) begin
            if (sa_rst) begin
               act_q[r][c]  <= '0;
               psum_q[r][c] <= '0;
            end else begin
               act_q[r][c]  <= act_in;
               psum_q[r][c] <= psum_in + prod;
            end
         end
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_deskew
      if (c == COLS - 1) begin : g_direct
         assign col_out[c] = psum_q[ROWS-1][c];
      end else begin : g_dly
         localparam int unsigned Depth = COLS - 1 - c;
         logic [ACC_WIDTH-1:0] dly_q [Depth];
         always_ff @(posedge sa_clk) begin
            if (sa_rst) begin
               for (int k = 0; k < int'(Depth); k++) dly_q[k] <= '0;
            end else begin
               dly_q[0] <= psum_q[ROWS-1][c];
               for (int k = 1; k < int'(Depth); k++) dly_q[k] <= dly_q[k-1];
            end
         end
         assign col_out[c] = dly_q[Depth-1];
      end
   end

   always_ff @(posedge sa_clk) begin
      if (sa_rst) begin
         sa_out <= '0;
      end else if (tok_q[Lat-2]) begin
         for (int c = 0; c < int'(COLS); c++) begin
            sa_out[c*ACC_WIDTH +: ACC_WIDTH] <= col_out[c];
         end
      end
   end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Directed bench: 2x2 arrays (40- and 32-bit accumulators, shared stimulus) and a 4x4 array.
module tb_systolic_array_nxn;

   localparam int unsigned DW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic            load2, w_valid2, in_valid2;
   logic [2*DW-1:0] w_in2, a_in2;
   logic            w_ready2, in_ready2, out_valid2, ok2;
   logic [79:0]     out2;
   logic            w_ready2n, in_ready2n, out_valid2n, ok2n;
   logic [63:0]     out2n;

   logic            load4, w_valid4, in_valid4;
   logic [4*DW-1:0] w_in4, a_in4;
   logic            w_ready4, in_ready4, out_valid4, ok4;
   logic [159:0]    out4;

   int checks, errors;

   systolic_array_nxn #(.DATA_WIDTH(16), .ACC_WIDTH(40), .ROWS(2), .COLS(2)) u_dut2 (
      .sa_clk(clk), .sa_rst(rst), .sa_load(load2), .sa_w_valid(w_valid2),
      .sa_w_ready(w_ready2), .sa_w_in(w_in2), .sa_in_valid(in_valid2),
      .sa_in_ready(in_ready2), .sa_a_in(a_in2), .sa_out_valid(out_valid2),
      .sa_out(out2), .sa_weights_ok(ok2)
   );

   systolic_array_nxn #(.DATA_WIDTH(16), .ACC_WIDTH(32), .ROWS(2), .COLS(2)) u_dut2n (
      .sa_clk(clk), .sa_rst(rst), .sa_load(load2), .sa_w_valid(w_valid2),
      .sa_w_ready(w_ready2n), .sa_w_in(w_in2), .sa_in_valid(in_valid2),
      .sa_in_ready(in_ready2n), .sa_a_in(a_in2), .sa_out_valid(out_valid2n),
      .sa_out(out2n), .sa_weights_ok(ok2n)
   );

   systolic_array_nxn #(.DATA_WIDTH(16), .ACC_WIDTH(40), .ROWS(4), .COLS(4)) u_dut4 (
      .sa_clk(clk), .sa_rst(rst), .sa_load(load4), .sa_w_valid(w_valid4),
      .sa_w_ready(w_ready4), .sa_w_in(w_in4), .sa_in_valid(in_valid4),
      .sa_in_ready(in_ready4), .sa_a_in(a_in4), .sa_out_valid(out_valid4),
      .sa_out(out4), .sa_weights_ok(ok4)
   );

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_w2(input string tag);
      int n;
      n = 0;
      while (!w_ready2 && n < 20) begin
         tick();
         n++;
      end
      check(tag, 160'(w_ready2), 160'(1));
   endtask

   task automatic beats2(input logic [31:0] b0, input logic [31:0] b1);
      w_valid2 = 1'b1;
      w_in2    = b0;
      tick();
      w_in2    = b1;
      tick();
      w_valid2 = 1'b0;
   endtask

   // Returns edges from acceptance (inclusive) to the first sa_out_valid cycle.
   task automatic send2(input logic [31:0] a, output int lat);
      in_valid2 = 1'b1;
      a_in2     = a;
      tick();
      in_valid2 = 1'b0;
      lat = 1;
      while (!out_valid2 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   function automatic logic [159:0] exp_stream(input int k);
      logic [159:0] v;
      for (int c = 0; c < 4; c++) v[c*40 +: 40] = 40'(k + c);
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int lat, nv, early, n_out, first, last;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      load2 = 1'b0; w_valid2 = 1'b0; in_valid2 = 1'b0; w_in2 = '0; a_in2 = '0;
      load4 = 1'b0; w_valid4 = 1'b0; in_valid4 = 1'b0; w_in4 = '0; a_in4 = '0;
      tick();
      tick();
      check("rst_w_ready", 160'(w_ready2), 160'(0));
      check("rst_in_ready", 160'({in_ready2, in_ready2n, in_ready4}), 160'(0));
      check("rst_out_valid", 160'(out_valid2), 160'(0));
      check("rst_out", 160'(out2), 160'(0));
      check("rst_ok", 160'(ok2), 160'(0));
      check("rst_out4", out4, 160'(0));
      rst = 1'b0;

      // Activations offered with no weights loaded must be ignored.
      in_valid2 = 1'b1;
      a_in2 = {16'd1, 16'd1};
      nv = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (in_ready2 || out_valid2) nv++;
      end
      in_valid2 = 1'b0;
      check("no_load_accept", 160'(nv), 160'(0));

      // W = [[1,2],[3,4]]: bottom row (3,4) first.
      load2 = 1'b1;
      tick();
      load2 = 1'b0;
      wait_w2("load_w_ready");
      beats2({16'd4, 16'd3}, {16'd2, 16'd1});
      check("loaded_ok", 160'(ok2), 160'(1));
      check("loaded_in_ready", 160'(in_ready2), 160'(1));
      check("loaded_w_ready", 160'(w_ready2), 160'(0));

      send2({16'd6, 16'd5}, lat);
      check("basic_lat", 160'(lat), 160'(4));
      check("basic_y", 160'(out2), 160'({40'd34, 40'd23}));
      tick();
      check("valid_pulse", 160'(out_valid2), 160'(0));
      check("out_hold", 160'(out2), 160'({40'd34, 40'd23}));

      send2({16'd3, 16'hFFFE}, lat);
      check("signed_y", 160'(out2), 160'({40'd8, 40'd7}));

      // Reload requested in the same cycle as a vector: vector uses the old weights.
      load2 = 1'b1;
      in_valid2 = 1'b1;
      a_in2 = {16'd1, 16'd1};
      tick();
      load2 = 1'b0;
      in_valid2 = 1'b0;
      check("coll_in_ready_drop", 160'(in_ready2), 160'(0));
      lat = 1;
      early = 0;
      while (!out_valid2 && lat < 20) begin
         if (w_ready2) early++;
         tick();
         lat++;
      end
      if (w_ready2) early++;
      check("coll_lat", 160'(lat), 160'(4));
      check("coll_y", 160'(out2), 160'({40'd6, 40'd4}));
      check("coll_no_early_w_ready", 160'(early), 160'(0));
      wait_w2("coll_w_ready_rise");
      beats2({16'd2, 16'd2}, {16'd2, 16'd2});
      send2({16'd1, 16'd1}, lat);
      check("reload_y", 160'(out2), 160'({40'd4, 40'd4}));

      // Reload from an idle READY: exactly one cycle in DRAIN.
      load2 = 1'b1;
      tick();
      load2 = 1'b0;
      check("drain_w_ready", 160'({w_ready2, w_ready2n}), 160'(0));
      check("drain_ok", 160'(ok2), 160'(0));
      tick();
      check("drain_one_cycle", 160'({w_ready2, w_ready2n}), 160'(3));
      beats2({16'h8000, 16'h8000}, {16'h8000, 16'h8000});
      check("wrap_ok32", 160'(ok2n), 160'(1));
      send2({16'h8000, 16'h8000}, lat);
      check("wrap_valid32", 160'(out_valid2n), 160'(1));
      check("wrap32_y", 160'(out2n), 160'({32'h80000000, 32'h80000000}));
      check("nowrap40_y", 160'(out2), 160'({40'h0080000000, 40'h0080000000}));

      // 4x4 identity: beat j lands in row 3-j.
      load4 = 1'b1;
      tick();
      load4 = 1'b0;
      check("l4_w_ready", 160'(w_ready4), 160'(1));
      w_valid4 = 1'b1;
      for (int j = 0; j < 4; j++) begin
         w_in4 = '0;
         w_in4[16*(3-j) +: 16] = 16'd1;
         tick();
      end
      w_valid4 = 1'b0;
      check("l4_ok", 160'(ok4), 160'(1));

      n_out = 0;
      first = -1;
      last = -1;
      for (int t = 0; t < 30; t++) begin
         if (t < 8) begin
            in_valid4 = 1'b1;
            for (int r = 0; r < 4; r++) a_in4[r*16 +: 16] = 16'(t + 1 + r);
         end else begin
            in_valid4 = 1'b0;
         end
         tick();
         if (out_valid4) begin
            if (n_out < 8) check("stream_y", out4, exp_stream(n_out + 1));
            if (first < 0) first = t;
            last = t;
            n_out++;
         end
      end
      check("stream_count", 160'(n_out), 160'(8));
      check("stream_lat", 160'(first), 160'(7));
      check("stream_contig", 160'(last - first), 160'(7));

      // Reset with three vectors in flight.
      in_valid4 = 1'b1;
      nv = 0;
      for (int i = 0; i < 3; i++) begin
         for (int r = 0; r < 4; r++) a_in4[r*16 +: 16] = 16'(10 + i + r);
         tick();
      end
      in_valid4 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (out_valid4) nv++;
      end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (out_valid4) nv++;
      end
      rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid4) nv++;
      end
      check("mid_rst_no_valid", 160'(nv), 160'(0));
      check("mid_rst_ok", 160'(ok4), 160'(0));
      check("mid_rst_readies", 160'({w_ready4, in_ready4}), 160'(0));
      check("mid_rst_out", out4, 160'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
